// File: rtl/encryption_fsm_if.sv
// Handshake bundle between the AES-128 encryption sequencer and its environment.
// The abort signal exists only when ENC_ABORT_EN is defined.
interface encryption_fsm_if;
  logic       start;
  logic       key_valid;
`ifdef ENC_ABORT_EN
  logic       abort;
`endif
  logic       mux_sel;
  logic       req_key;
  logic [3:0] round_num;
  logic       last_round;
  logic       busy;
  logic       done;

  modport master (
`ifdef ENC_ABORT_EN
    output abort,
`endif
    output start, key_valid,
    input  mux_sel, req_key, round_num, last_round, busy, done
  );

  modport slave (
`ifdef ENC_ABORT_EN
    input  abort,
`endif
    input  start, key_valid,
    output mux_sel, req_key, round_num, last_round, busy, done
  );
endinterface

// File: rtl/encryption_fsm.sv
// AES-128 encryption round sequencer: walks rounds 0..NUM_ROUNDS, fetches one key per round.
// Optional ENC_ABORT_EN adds an abort input that returns the FSM to IDLE without a done pulse.
//
// state         | meaning
// IDLE          | waiting for start
// INITIAL_ROUND | plaintext XOR key0 loaded into the state register
// KEY_WAIT      | requesting the round key for round_num
// MID_ROUND     | datapath running rounds 1..NUM_ROUNDS-1
// FINAL_ROUND   | last round, MixColumns bypassed
// DONE          | ciphertext valid for one cycle
module encryption_fsm #(
  parameter int NUM_ROUNDS   = 10,
  parameter int ROUND_CYCLES = 3
) (
  input logic              clk,
  input logic              reset_n,
  encryption_fsm_if.slave  bus
);

  localparam int CW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INITIAL_ROUND,
    KEY_WAIT,
    MID_ROUND,
    FINAL_ROUND,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    round_count;
  logic [CW-1:0] cycle_count;
  logic          abort_req;

`ifdef ENC_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      round_count <= 4'd0;
      cycle_count <= '0;
    end else if (abort_req && (state != IDLE)) begin
      state       <= IDLE;
      round_count <= 4'd0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= INITIAL_ROUND;
            round_count <= 4'd0;
          end
        end
        INITIAL_ROUND: begin
          state       <= KEY_WAIT;
          round_count <= 4'd1;
        end
        KEY_WAIT: begin
          if (bus.key_valid) begin
            cycle_count <= CW'(ROUND_CYCLES - 1);
            state       <= (round_count == 4'(NUM_ROUNDS)) ? FINAL_ROUND : MID_ROUND;
          end
        end
        MID_ROUND: begin
          if (cycle_count != '0) begin
            cycle_count <= cycle_count - CW'(1);
          end else begin
            round_count <= round_count + 4'd1;
            state       <= KEY_WAIT;
          end
        end
        FINAL_ROUND: begin
          // round_count stays at NUM_ROUNDS so DONE still reports the final round
          if (cycle_count != '0) begin
            cycle_count <= cycle_count - CW'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          state       <= IDLE;
          round_count <= 4'd0;
          cycle_count <= '0;
        end
        default: begin
          state       <= IDLE;
          round_count <= 4'd0;
          cycle_count <= '0;
        end
      endcase
    end
  end

  assign bus.mux_sel    = (state != IDLE) && (state != INITIAL_ROUND);
  assign bus.req_key    = (state == KEY_WAIT);
  assign bus.round_num  = round_count;
  assign bus.last_round = (state == FINAL_ROUND);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_encryption_fsm.sv
// Self-checking bench for encryption_fsm: table of operation scenarios checked per cycle
// against a timeline model through a scoreboard queue, plus reset/abort sequences.
module tb_encryption_fsm;
  localparam int NR = 10;
  localparam int RC = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  encryption_fsm_if bus();

  encryption_fsm #(.NUM_ROUNDS(NR), .ROUND_CYCLES(RC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic       mux_sel;
    logic       req_key;
    logic [3:0] rn;
    logic       last;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    int k;
    exp_t e;
  } sb_t;

  typedef struct {
    int stall_round;
    int stall_len;
    bit start_r6;
    bit start_done;
    int exp_done;
  } vec_t;

  vec_t vecs[4];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  int   done_seen, done_cnt, last_cnt, last_bad;
  exp_t act;

  assign act = {bus.mux_sel, bus.req_key, bus.round_num, bus.last_round, bus.busy, bus.done};

  task automatic check(input string name, input exp_t a, input exp_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got mux=%b req=%b rn=%0d last=%b busy=%b done=%b, expected mux=%b req=%b rn=%0d last=%b busy=%b done=%b",
               name, a.mux_sel, a.req_key, a.rn, a.last, a.busy, a.done,
               e.mux_sel, e.req_key, e.rn, e.last, e.busy, e.done);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_checks++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  // Expected outputs for cycle k after the start cycle (k=0), derived from the round timeline.
  function automatic exp_t model(input int k, input int sr, input int sl, output bit stall);
    exp_t e;
    int   t;
    e = '0;
    stall = 1'b0;
    if (k <= 0) return e;
    if (k == 1) begin
      e.busy = 1'b1;
      return e;
    end
    t = k - 2;
    for (int r = 1; r <= NR; r++) begin
      int w;
      w = 1 + ((r == sr) ? sl : 0);
      if (t < w) begin
        e.mux_sel = 1'b1; e.req_key = 1'b1; e.rn = 4'(r); e.busy = 1'b1;
        stall = (r == sr) && (t < sl);
        return e;
      end
      t -= w;
      if (t < RC) begin
        e.mux_sel = 1'b1; e.rn = 4'(r); e.last = (r == NR); e.busy = 1'b1;
        return e;
      end
      t -= RC;
    end
    if (t == 0) begin
      e.mux_sel = 1'b1; e.rn = 4'(NR); e.busy = 1'b1; e.done = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    sb_t s;
    #2;
    if (chk_en && (sb_q.size() > 0)) begin
      s = sb_q.pop_front();
      check($sformatf("cycle_%0d", s.k), act, s.e);
      if (act.done) begin
        done_cnt++;
        if (done_seen < 0) done_seen = s.k;
      end
      if (act.last) begin
        if (act.rn == 4'(NR)) last_cnt++;
        else last_bad++;
      end
    end
  end

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    bit   st;
    int   len;
    v = vecs[idx];
    len = v.exp_done + 3;
    done_seen = -1; done_cnt = 0; last_cnt = 0; last_bad = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk); #1;
      e = model(k, v.stall_round, v.stall_len, st);
      bus.start = (k == 0) || (v.start_r6 && (k == 23)) || (v.start_done && (k == v.exp_done));
      bus.key_valid = !st;
      sb_q.push_back('{k, e});
    end
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.key_valid = 1'b1;
    #3;
    check_int($sformatf("v%0d_done_cycle", idx), done_seen, v.exp_done);
    check_int($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
    check_int($sformatf("v%0d_last_round_cycles", idx), last_cnt, RC);
    check_int($sformatf("v%0d_last_round_early", idx), last_bad, 0);
    check_int($sformatf("v%0d_sb_drain", idx), sb_q.size(), 0);
  endtask

  initial begin
    int dn;
    bus.start = 1'b0;
    bus.key_valid = 1'b0;
`ifdef ENC_ABORT_EN
    bus.abort = 1'b0;
`endif
    vecs[0] = '{0,  0, 1'b0, 1'b0, 42};
    vecs[1] = '{3,  5, 1'b0, 1'b0, 47};
    vecs[2] = '{10, 2, 1'b1, 1'b1, 44};
    vecs[3] = '{1,  1, 1'b0, 1'b0, 43};

    #1;
    bus.start = 1'b1;
    check("reset_hold", act, '0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_hold_start", act, '0);
    bus.start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk); #1;
    check("idle_after_reset", act, '0);

    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) run_vec(i);
    chk_en = 1'b0;

    // Reset during round 4 MID_ROUND (cycle 15 after the start cycle).
    @(negedge clk); #1;
    bus.start = 1'b1;
    bus.key_valid = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      bus.start = 1'b0;
    end
    check_int("pre_reset_round", int'(act.rn), 4);
    check_int("pre_reset_last", int'(act.req_key), 0);
    reset_n = 1'b0;
    #1;
    check("reset_mid_op", act, '0);
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (act.done) dn++;
    end
    check_int("reset_no_done", dn, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (act.busy) dn++;
    end
    check_int("reset_stays_idle", dn, 0);

    chk_en = 1'b1;
    run_vec(0);
    chk_en = 1'b0;

`ifdef ENC_ABORT_EN
    @(negedge clk); #1;
    bus.start = 1'b1;
    bus.key_valid = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk); #1;
      bus.start = 1'b0;
    end
    check_int("abort_pre_round", int'(act.rn), 7);
    check_int("abort_pre_req", int'(act.req_key), 1);
    bus.abort = 1'b1;
    @(negedge clk); #1;
    check("abort_to_idle", act, '0);
    bus.start = 1'b1;
    @(negedge clk); #1;
    check("abort_start_idle", act, '0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk); #1;
    check("abort_release_idle", act, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
